// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
// Round-robin front end for a shared 8-element dot-product unit. It grants one
// requester, pulses START, steps the A/B read addresses alongside the unit's
// multiply-accumulate cycles, and returns the result (or a timeout error)
// through a valid/ready response port.
//
// Handshakes:
//   REQ/GNT       : REQ[i] stays high until GNT[i] pulses for one cycle; GNT is
//                   issued only from IDLE, so a pending response blocks grants.
//   RESP          : RESP_VALID rises with RESP_ID/RESP_DATA/RESP_ERR and all
//                   four hold steady until an edge samples RESP_READY=1; that
//                   edge completes the transfer and drops RESP_VALID.
//   CS_START/DONE : CS_START is high for one cycle; DONE is sticky from the
//                   previous operation, so it is only trusted from idx=8 on.
module dot_product_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [1:0]          REQ,
  input  logic [2*ADDR_W-1:0] REQ_BASE_A,
  input  logic [2*ADDR_W-1:0] REQ_BASE_B,
  output logic [1:0]          GNT,
  output logic                RESP_VALID,
  input  logic                RESP_READY,
  output logic                RESP_ID,
  output logic [15:0]         RESP_DATA,
  output logic                RESP_ERR,
  output logic                CS_START,
  input  logic                CS_DONE,
  input  logic [15:0]         CS_RESULT,
  output logic [ADDR_W-1:0]   ADDR_A,
  output logic [ADDR_W-1:0]   ADDR_B,
  output logic                BUSY,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_DRAIN = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // The compute unit is not reset, so after reset we wait out any operation
  // that might still be in flight before accepting new work.
  localparam logic [3:0] DRAIN_CYCLES = 4'd9;

  state_t              state, state_n;
  logic [3:0]          drain_cnt, drain_cnt_n;
  logic                rr_last, rr_last_n;
  logic                id, id_n;
  logic [ADDR_W-1:0]   base_a, base_a_n;
  logic [ADDR_W-1:0]   base_b, base_b_n;
  logic [3:0]          idx, idx_n;

  logic [1:0]          gnt_n;
  logic                cs_start_n;
  logic                resp_valid_n;
  logic                resp_id_n;
  logic [15:0]         resp_data_n;
  logic                resp_err_n;
  logic [ADDR_W-1:0]   addr_a_n;
  logic [ADDR_W-1:0]   addr_b_n;
  logic                busy_n;

  logic                win;
  logic [3:0]          idx_inc;
  logic [2:0]          off;

  assign dbg_state = state;

  // Next-state and next-output logic; every register's next value is computed here.
  always_comb begin
    state_n      = state;
    drain_cnt_n  = drain_cnt;
    rr_last_n    = rr_last;
    id_n         = id;
    base_a_n     = base_a;
    base_b_n     = base_b;
    idx_n        = idx;
    gnt_n        = 2'b00;
    cs_start_n   = 1'b0;
    resp_valid_n = RESP_VALID;
    resp_id_n    = RESP_ID;
    resp_data_n  = RESP_DATA;
    resp_err_n   = RESP_ERR;
    addr_a_n     = ADDR_A;
    addr_b_n     = ADDR_B;
    busy_n       = BUSY;
    win          = 1'b0;
    idx_inc      = idx + 4'd1;
    // Address offset saturates at 7: the unit has consumed all 8 elements by then.
    off          = (idx_inc > 4'd7) ? 3'd7 : idx_inc[2:0];

    case (state)
      S_DRAIN: begin
        if (drain_cnt <= 4'd1) begin
          drain_cnt_n = 4'd0;
          state_n     = S_IDLE;
          busy_n      = 1'b0;
        end else begin
          drain_cnt_n = drain_cnt - 4'd1;
        end
      end

      S_IDLE: begin
        if (REQ != 2'b00) begin
          // Single requester wins outright; a tie goes to whoever was not served last.
          win        = (REQ == 2'b11) ? ~rr_last : REQ[1];
          id_n       = win;
          base_a_n   = win ? REQ_BASE_A[ADDR_W +: ADDR_W] : REQ_BASE_A[0 +: ADDR_W];
          base_b_n   = win ? REQ_BASE_B[ADDR_W +: ADDR_W] : REQ_BASE_B[0 +: ADDR_W];
          addr_a_n   = base_a_n;
          addr_b_n   = base_b_n;
          gnt_n      = win ? 2'b10 : 2'b01;
          cs_start_n = 1'b1;
          busy_n     = 1'b1;
          state_n    = S_START;
        end
      end

      S_START: begin
        idx_n    = 4'd0;
        addr_a_n = base_a;
        addr_b_n = base_b;
        state_n  = S_RUN;
      end

      S_RUN: begin
        idx_n    = idx_inc;
        addr_a_n = base_a + ADDR_W'(off);
        addr_b_n = base_b + ADDR_W'(off);
        if ((idx >= 4'd8) && CS_DONE) begin
          resp_data_n  = CS_RESULT;
          resp_err_n   = 1'b0;
          resp_id_n    = id;
          resp_valid_n = 1'b1;
          state_n      = S_RESP;
        end else if (idx == 4'(TIMEOUT)) begin
          resp_data_n  = 16'd0;
          resp_err_n   = 1'b1;
          resp_id_n    = id;
          resp_valid_n = 1'b1;
          state_n      = S_RESP;
        end
      end

      S_RESP: begin
        if (RESP_READY) begin
          resp_valid_n = 1'b0;
          rr_last_n    = id;
          busy_n       = 1'b0;
          state_n      = S_IDLE;
        end
      end

      default: begin
        state_n = S_DRAIN;
        busy_n  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset lands in DRAIN with BUSY high.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_DRAIN;
      drain_cnt  <= DRAIN_CYCLES;
      rr_last    <= 1'b1;
      id         <= 1'b0;
      base_a     <= '0;
      base_b     <= '0;
      idx        <= 4'd0;
      GNT        <= 2'b00;
      CS_START   <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_ID    <= 1'b0;
      RESP_DATA  <= 16'd0;
      RESP_ERR   <= 1'b0;
      ADDR_A     <= '0;
      ADDR_B     <= '0;
      BUSY       <= 1'b1;
    end else begin
      state      <= state_n;
      drain_cnt  <= drain_cnt_n;
      rr_last    <= rr_last_n;
      id         <= id_n;
      base_a     <= base_a_n;
      base_b     <= base_b_n;
      idx        <= idx_n;
      GNT        <= gnt_n;
      CS_START   <= cs_start_n;
      RESP_VALID <= resp_valid_n;
      RESP_ID    <= resp_id_n;
      RESP_DATA  <= resp_data_n;
      RESP_ERR   <= resp_err_n;
      ADDR_A     <= addr_a_n;
      ADDR_B     <= addr_b_n;
      BUSY       <= busy_n;
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a behavioural compute unit
// and A/B vector memories.
module tb_dot_product_sequencer;

  localparam int ADDR_W = 6;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                RESET_N;
  logic [1:0]          REQ;
  logic [2*ADDR_W-1:0] REQ_BASE_A;
  logic [2*ADDR_W-1:0] REQ_BASE_B;
  logic [1:0]          GNT;
  logic                RESP_VALID;
  logic                RESP_READY;
  logic                RESP_ID;
  logic [15:0]         RESP_DATA;
  logic                RESP_ERR;
  logic                CS_START;
  logic                CS_DONE;
  logic [15:0]         CS_RESULT;
  logic [ADDR_W-1:0]   ADDR_A;
  logic [ADDR_W-1:0]   ADDR_B;
  logic                BUSY;
  logic [2:0]          dbg_state;

  dot_product_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ),
    .REQ_BASE_A(REQ_BASE_A), .REQ_BASE_B(REQ_BASE_B),
    .GNT(GNT), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_ID(RESP_ID), .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR),
    .CS_START(CS_START), .CS_DONE(CS_DONE), .CS_RESULT(CS_RESULT),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .BUSY(BUSY), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- memories and compute unit model ----------------
  logic [7:0]  mem_a [0:63];
  logic [7:0]  mem_b [0:63];
  logic        tie_done_low = 1'b0;
  logic [15:0] u_acc  = 16'd0;
  logic [3:0]  u_cnt  = 4'd8;
  logic        u_done = 1'b0;

  assign CS_DONE   = u_done & ~tie_done_low;
  assign CS_RESULT = u_acc;

  // Unit: START initialises; then one element per edge for 8 edges; DONE is sticky.
  always @(posedge CLK) begin
    if (CS_START) begin
      u_acc  <= 16'd0;
      u_cnt  <= 4'd0;
      u_done <= 1'b0;
    end else if (u_cnt < 4'd8) begin
      u_acc <= u_acc + 16'(mem_a[ADDR_A]) * 16'(mem_b[ADDR_B]);
      u_cnt <= u_cnt + 4'd1;
      if (u_cnt == 4'd7) u_done <= 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  logic [ADDR_W-1:0] addr_log [0:40];
  int                gnt_during_op;

  task automatic set_req(input logic [1:0] r, input logic [5:0] a0, input logic [5:0] b0,
                         input logic [5:0] a1, input logic [5:0] b1);
    REQ_BASE_A = {a1, a0};
    REQ_BASE_B = {b1, b0};
    REQ        = r;
  endtask

  // Returns the grant seen and how many negedges it took (0 grant = none within bound).
  task automatic wait_gnt(output logic [1:0] g, output int waited);
    g = 2'b00;
    waited = 0;
    while (waited < 20) begin
      @(negedge CLK);
      waited++;
      if (GNT != 2'b00) begin
        g = GNT;
        break;
      end
    end
  endtask

  // Negedges from the grant sample until RESP_VALID; logs ADDR_A per cycle.
  task automatic wait_valid(output int k);
    k = 0;
    gnt_during_op = 0;
    while (k < 40) begin
      @(negedge CLK);
      k++;
      addr_log[k] = ADDR_A;
      if (GNT != 2'b00) gnt_during_op++;
      if (RESP_VALID) break;
    end
  endtask

  task automatic count_drain(output int k);
    k = 0;
    while (k < 30) begin
      @(negedge CLK);
      k++;
      if (!BUSY) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    RESET_N = 1'b0; REQ = 2'b00; REQ_BASE_A = '0; REQ_BASE_B = '0; RESP_READY = 1'b1;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({GNT, CS_START, RESP_VALID, RESP_ERR, RESP_ID} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {GNT, CS_START, RESP_VALID, RESP_ERR, RESP_ID});
    end
    vectors++;
    if ({RESP_DATA, ADDR_A, ADDR_B} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_data: data=%0d addr_a=%0d addr_b=%0d expected 0", RESP_DATA, ADDR_A, ADDR_B);
    end
    vectors++;
    if (BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 1", BUSY);
    end
    RESET_N = 1'b1;
    count_drain(k);
    vectors++;
    if (k !== 9) begin
      miscompares++;
      $display("FAIL reset_drain_len: BUSY fell after %0d edges expected 9", k);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [15:0] exp_d [3] = '{16'd72, 16'd28, 16'd72};
    logic [1:0]  g;
    int w, k;
    RESP_READY = 1'b1;
    set_req(2'b11, 6'd0, 6'd8, 6'd16, 6'd24);
    for (int i = 0; i < 3; i++) begin
      wait_gnt(g, w);
      if (i == 2) REQ = 2'b00;
      vectors++;
      if (g !== exp_g[i]) begin
        miscompares++;
        $display("FAIL arb_gnt[%0d]: got %b expected %b", i, g, exp_g[i]);
      end
      if (i > 0) begin
        vectors++;
        if (w !== 2) begin
          miscompares++;
          $display("FAIL b2b_gap[%0d]: grant after %0d cycles expected 2", i, w);
        end
      end
      wait_valid(k);
      vectors++;
      if ({RESP_ID, RESP_DATA, RESP_ERR} !== {~exp_g[i][0], exp_d[i], 1'b0}) begin
        miscompares++;
        $display("FAIL arb_resp[%0d]: id=%b data=%0d err=%b expected id=%b data=%0d err=0",
                 i, RESP_ID, RESP_DATA, RESP_ERR, ~exp_g[i][0], exp_d[i]);
      end
    end
    @(negedge CLK);
    vectors++;
    if ({RESP_VALID, BUSY} !== 2'b00) begin
      miscompares++;
      $display("FAIL arb_idle: valid=%b busy=%b expected 0 0", RESP_VALID, BUSY);
    end
  endtask

  task automatic test_single_op();
    logic [1:0] g;
    int w, k;
    RESP_READY = 1'b1;
    set_req(2'b01, 6'd0, 6'd8, 6'd0, 6'd0);
    wait_gnt(g, w);
    REQ = 2'b00;
    vectors++;
    if (g !== 2'b01) begin
      miscompares++;
      $display("FAIL single_gnt: got %b expected 01", g);
    end
    wait_valid(k);
    vectors++;
    if (gnt_during_op !== 0) begin
      miscompares++;
      $display("FAIL single_gnt_pulse: GNT high %0d extra cycles expected 0", gnt_during_op);
    end
    vectors++;
    if (k !== 10) begin
      miscompares++;
      $display("FAIL single_latency: valid after %0d cycles expected 10", k);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (addr_log[j+1] !== ADDR_W'(j)) begin
        miscompares++;
        $display("FAIL single_addr[%0d]: got %0d expected %0d", j, addr_log[j+1], j);
      end
    end
    vectors++;
    if ({RESP_ID, RESP_DATA, RESP_ERR} !== {1'b0, 16'd72, 1'b0}) begin
      miscompares++;
      $display("FAIL single_resp: id=%b data=%0d err=%b expected id=0 data=72 err=0", RESP_ID, RESP_DATA, RESP_ERR);
    end
    @(negedge CLK);
    vectors++;
    if (RESP_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL single_valid_drop: got %b expected 0", RESP_VALID);
    end
  endtask

  task automatic test_address_wrap();
    logic [5:0] exp_a [8] = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2, 6'd3};
    logic [1:0] g;
    int w, k;
    RESP_READY = 1'b1;
    set_req(2'b01, 6'd60, 6'd8, 6'd0, 6'd0);
    wait_gnt(g, w);
    REQ = 2'b00;
    wait_valid(k);
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (addr_log[j+1] !== exp_a[j]) begin
        miscompares++;
        $display("FAIL wrap_addr[%0d]: got %0d expected %0d", j, addr_log[j+1], exp_a[j]);
      end
    end
    vectors++;
    if (RESP_DATA !== 16'd112) begin
      miscompares++;
      $display("FAIL wrap_data: got %0d expected 112", RESP_DATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    int w, k;
    RESP_READY = 1'b0;
    set_req(2'b01, 6'd0, 6'd8, 6'd16, 6'd24);
    wait_gnt(g, w);
    REQ = 2'b00;
    wait_valid(k);
    vectors++;
    if ({RESP_VALID, RESP_DATA} !== {1'b1, 16'd72}) begin
      miscompares++;
      $display("FAIL bp_first: valid=%b data=%0d expected 1 72", RESP_VALID, RESP_DATA);
    end
    REQ = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      vectors++;
      if ({RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR, GNT} !== {1'b1, 1'b0, 16'd72, 1'b0, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%b data=%0d err=%b gnt=%b expected 1 0 72 0 00",
                 c, RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR, GNT);
      end
    end
    RESP_READY = 1'b1;
    wait_gnt(g, w);
    REQ = 2'b00;
    vectors++;
    if ({g, w[3:0]} !== {2'b10, 4'd2}) begin
      miscompares++;
      $display("FAIL bp_next_gnt: gnt=%b after %0d cycles expected 10 after 2", g, w);
    end
    wait_valid(k);
    vectors++;
    if ({RESP_ID, RESP_DATA} !== {1'b1, 16'd28}) begin
      miscompares++;
      $display("FAIL bp_second: id=%b data=%0d expected 1 28", RESP_ID, RESP_DATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    int w, k;
    RESP_READY = 1'b1;
    tie_done_low = 1'b1;
    set_req(2'b01, 6'd0, 6'd8, 6'd0, 6'd0);
    wait_gnt(g, w);
    REQ = 2'b00;
    wait_valid(k);
    vectors++;
    if (k !== 17) begin
      miscompares++;
      $display("FAIL timeout_latency: valid after %0d cycles expected 17", k);
    end
    vectors++;
    if ({RESP_VALID, RESP_ERR, RESP_DATA} !== {1'b1, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL timeout_resp: valid=%b err=%b data=%0d expected 1 1 0", RESP_VALID, RESP_ERR, RESP_DATA);
    end
    @(negedge CLK);
    vectors++;
    if ({RESP_VALID, BUSY} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_idle: valid=%b busy=%b expected 0 0", RESP_VALID, BUSY);
    end
    tie_done_low = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] g;
    int w, k;
    RESP_READY = 1'b1;
    set_req(2'b01, 6'd0, 6'd8, 6'd0, 6'd0);
    wait_gnt(g, w);
    REQ = 2'b00;
    repeat (5) @(negedge CLK);
    vectors++;
    if (ADDR_A !== 6'd4) begin
      miscompares++;
      $display("FAIL midrun_addr: got %0d expected 4", ADDR_A);
    end
    RESET_N = 1'b0;
    #1;
    vectors++;
    if ({GNT, CS_START, RESP_VALID, ADDR_A, ADDR_B, BUSY} !== {2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrun_clear: gnt=%b start=%b valid=%b addr_a=%0d addr_b=%0d busy=%b expected 00 0 0 0 0 1",
               GNT, CS_START, RESP_VALID, ADDR_A, ADDR_B, BUSY);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    count_drain(k);
    vectors++;
    if (k !== 9) begin
      miscompares++;
      $display("FAIL midrun_drain_len: BUSY fell after %0d edges expected 9", k);
    end
    set_req(2'b01, 6'd0, 6'd8, 6'd0, 6'd0);
    wait_gnt(g, w);
    REQ = 2'b00;
    wait_valid(k);
    vectors++;
    if ({k[4:0], RESP_DATA, RESP_ERR} !== {5'd10, 16'd72, 1'b0}) begin
      miscompares++;
      $display("FAIL midrun_next_op: latency=%0d data=%0d err=%b expected 10 72 0", k, RESP_DATA, RESP_ERR);
    end
    @(negedge CLK);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    for (int i = 0; i < 8; i++) begin
      mem_a[i]      = 8'(i + 1);  // A[0..7] = 1..8
      mem_b[8 + i]  = 8'd2;       // B[8..15] = 2
      mem_a[16 + i] = 8'd1;       // A[16..23] = 1
      mem_b[24 + i] = 8'(i);      // B[24..31] = 0..7
    end
    mem_a[60] = 8'd10; mem_a[61] = 8'd11; mem_a[62] = 8'd12; mem_a[63] = 8'd13;

    test_reset();
    test_arbitration();
    test_single_op();
    test_address_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1);
  end

endmodule
